// File: rtl/rv32i_decode_exec.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_decode_exec
//  Purpose  : Single-cycle RV32I decode/execute slice. Decodes the opcode
//             into register-file / data-memory controls, runs the ALU,
//             evaluates the branch condition and computes the next PC.
//             A sticky illegal-instruction flag is the only state.
//  Ports    : clk, rst (async, active-high)
//             instruction, pc, imm, rs1_data, rs2_data   -> inputs
//             rf_rsel1/2, rf_wsel, rf_wen, dm_wen, rf_wdata_sel,
//             alu_op1_sel, alu_op2_sel, alu_operation, branch_condition,
//             alu_out, branch_taken, next_pc, illegal     -> outputs
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_decode_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      rf_rsel1,
    output logic [4:0]      rf_rsel2,
    output logic [4:0]      rf_wsel,
    output logic            rf_wen,
    output logic            dm_wen,
    output logic [1:0]      rf_wdata_sel,
    output logic            alu_op1_sel,
    output logic            alu_op2_sel,
    output logic [3:0]      alu_operation,
    output logic [2:0]      branch_condition,
    output logic [XLEN-1:0] alu_out,
    output logic            branch_taken,
    output logic [XLEN-1:0] next_pc,
    output logic            illegal
);

    // Opcodes
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    // ALU operation codes
    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_SLL  = 4'd2;
    localparam logic [3:0] c_ALU_SLT  = 4'd3;
    localparam logic [3:0] c_ALU_SLTU = 4'd4;
    localparam logic [3:0] c_ALU_XOR  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_OR   = 4'd8;
    localparam logic [3:0] c_ALU_AND  = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    // Writeback sources
    localparam logic [1:0] c_WB_ALU  = 2'd0;
    localparam logic [1:0] c_WB_DM   = 2'd1;
    localparam logic [1:0] c_WB_PC4  = 2'd2;
    localparam logic [1:0] c_WB_NONE = 2'd3;

    // Branch condition codes
    localparam logic [2:0] c_BR_EQ    = 3'b000;
    localparam logic [2:0] c_BR_NE    = 3'b001;
    localparam logic [2:0] c_BR_NEVER = 3'b010;
    localparam logic [2:0] c_BR_ALWAYS = 3'b011;
    localparam logic [2:0] c_BR_LT    = 3'b100;
    localparam logic [2:0] c_BR_GE    = 3'b101;
    localparam logic [2:0] c_BR_LTU   = 3'b110;
    localparam logic [2:0] c_BR_GEU   = 3'b111;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_funct7_b5;
    logic            w_known;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_pc_plus4;
    logic [4:0]      w_shamt;
    logic            r_illegal;
    logic            w_unused;

    assign w_opcode    = instruction[6:0];
    assign w_funct3    = instruction[14:12];
    assign w_funct7_b5 = instruction[30];

    // Remaining funct7 bits carry no meaning for RV32I base decode.
    assign w_unused = ^{instruction[31], instruction[29:25]};

    assign rf_rsel1 = instruction[19:15];
    assign rf_rsel2 = instruction[24:20];
    assign rf_wsel  = instruction[11:7];

    // funct3 -> ALU op; 'alt' selects SUB (000) or SRA (101).
    function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SLT;
            3'b011:  op = c_ALU_SLTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    always_comb begin
        rf_wen           = 1'b0;
        dm_wen           = 1'b0;
        rf_wdata_sel     = c_WB_NONE;
        alu_op1_sel      = 1'b0;
        alu_op2_sel      = 1'b0;
        alu_operation    = c_ALU_ADD;
        branch_condition = c_BR_NEVER;
        w_known          = 1'b1;
        case (w_opcode)
            c_OP_R: begin
                rf_wen        = 1'b1;
                rf_wdata_sel  = c_WB_ALU;
                alu_operation = f3_to_alu(w_funct3, w_funct7_b5);
            end
            c_OP_I: begin
                rf_wen        = 1'b1;
                rf_wdata_sel  = c_WB_ALU;
                alu_op2_sel   = 1'b1;
                // Bit 30 is part of the immediate except for SRAI.
                alu_operation = f3_to_alu(w_funct3,
                                          w_funct7_b5 && (w_funct3 == 3'b101));
            end
            c_OP_LOAD: begin
                rf_wen       = 1'b1;
                rf_wdata_sel = c_WB_DM;
                alu_op2_sel  = 1'b1;
            end
            c_OP_STORE: begin
                dm_wen      = 1'b1;
                alu_op2_sel = 1'b1;
            end
            c_OP_BRANCH: begin
                alu_op1_sel      = 1'b1;
                alu_op2_sel      = 1'b1;
                branch_condition = w_funct3;
            end
            c_OP_JAL: begin
                rf_wen           = 1'b1;
                rf_wdata_sel     = c_WB_PC4;
                alu_op1_sel      = 1'b1;
                alu_op2_sel      = 1'b1;
                branch_condition = c_BR_ALWAYS;
            end
            c_OP_JALR: begin
                rf_wen           = 1'b1;
                rf_wdata_sel     = c_WB_PC4;
                alu_op2_sel      = 1'b1;
                branch_condition = c_BR_ALWAYS;
            end
            c_OP_LUI: begin
                rf_wen        = 1'b1;
                rf_wdata_sel  = c_WB_ALU;
                alu_op2_sel   = 1'b1;
                alu_operation = c_ALU_PASSB;
            end
            c_OP_AUIPC: begin
                rf_wen       = 1'b1;
                rf_wdata_sel = c_WB_ALU;
                alu_op1_sel  = 1'b1;
                alu_op2_sel  = 1'b1;
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign w_op_a  = alu_op1_sel ? pc  : rs1_data;
    assign w_op_b  = alu_op2_sel ? imm : rs2_data;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        alu_out = w_op_a + w_op_b;
        case (alu_operation)
            c_ALU_ADD:   alu_out = w_op_a + w_op_b;
            c_ALU_SUB:   alu_out = w_op_a - w_op_b;
            c_ALU_SLL:   alu_out = w_op_a << w_shamt;
            c_ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
            c_ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
            c_ALU_XOR:   alu_out = w_op_a ^ w_op_b;
            c_ALU_SRL:   alu_out = w_op_a >> w_shamt;
            c_ALU_SRA:   alu_out = $unsigned($signed(w_op_a) >>> w_shamt);
            c_ALU_OR:    alu_out = w_op_a | w_op_b;
            c_ALU_AND:   alu_out = w_op_a & w_op_b;
            c_ALU_PASSB: alu_out = w_op_b;
            default:     alu_out = w_op_a + w_op_b;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch condition: always compares the raw register operands, since
    // the ALU is busy computing the branch target.
    // ------------------------------------------------------------------
    always_comb begin
        case (branch_condition)
            c_BR_EQ:     branch_taken = (rs1_data == rs2_data);
            c_BR_NE:     branch_taken = (rs1_data != rs2_data);
            c_BR_LT:     branch_taken = ($signed(rs1_data) < $signed(rs2_data));
            c_BR_GE:     branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
            c_BR_LTU:    branch_taken = (rs1_data < rs2_data);
            c_BR_GEU:    branch_taken = (rs1_data >= rs2_data);
            c_BR_ALWAYS: branch_taken = 1'b1;
            default:     branch_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next PC
    // ------------------------------------------------------------------
    assign w_pc_plus4 = pc + 32'd4;

    always_comb begin
        case (w_opcode)
            c_OP_BRANCH: next_pc = branch_taken ? alu_out : w_pc_plus4;
            c_OP_JAL:    next_pc = alu_out;
            c_OP_JALR:   next_pc = {alu_out[XLEN-1:1], 1'b0};
            default:     next_pc = w_pc_plus4;
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky illegal-opcode flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (!w_known) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decode_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_decode_exec
//  Purpose  : Self-checking bench for rv32i_decode_exec. Directed vectors
//             are applied one per clock; an instruction-level reference
//             model is compared against every output each cycle, and a set
//             of hand-computed literals pins the model itself.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv32i_decode_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0000_0013;
    logic [31:0] pc = 32'h0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic [31:0] rs2_data = 32'h0;

    logic [4:0]  rf_rsel1, rf_rsel2, rf_wsel;
    logic        rf_wen, dm_wen;
    logic [1:0]  rf_wdata_sel;
    logic        alu_op1_sel, alu_op2_sel;
    logic [3:0]  alu_operation;
    logic [2:0]  branch_condition;
    logic [31:0] alu_out;
    logic        branch_taken;
    logic [31:0] next_pc;
    logic        illegal;

    int n_vec  = 0;
    int n_miss = 0;
    bit checking = 1'b0;

    rv32i_decode_exec #(.XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .instruction      (instruction),
        .pc               (pc),
        .imm              (imm),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .rf_rsel1         (rf_rsel1),
        .rf_rsel2         (rf_rsel2),
        .rf_wsel          (rf_wsel),
        .rf_wen           (rf_wen),
        .dm_wen           (dm_wen),
        .rf_wdata_sel     (rf_wdata_sel),
        .alu_op1_sel      (alu_op1_sel),
        .alu_op2_sel      (alu_op2_sel),
        .alu_operation    (alu_operation),
        .branch_condition (branch_condition),
        .alu_out          (alu_out),
        .branch_taken     (branch_taken),
        .next_pc          (next_pc),
        .illegal          (illegal)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: instruction semantics computed directly
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        wen;
        logic        dwen;
        logic [1:0]  wsel;
        logic        op1;
        logic        op2;
        logic [3:0]  aop;
        logic [2:0]  cond;
        logic [31:0] alu;
        logic        taken;
        logic [31:0] npc;
    } exp_t;

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + (~b) + 32'd1;
            4'd2:  return a << s;
            4'd3:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd4:  return {31'd0, a < b};
            4'd5:  return a ^ b;
            4'd6:  return a >> s;
            4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'd8:  return a | b;
            4'd9:  return a & b;
            default: return b;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] im, input logic [31:0] r1,
                                   input logic [31:0] r2);
        exp_t e;
        logic [2:0] f3;
        logic [3:0] f3op [8];
        logic [31:0] a, b;
        f3 = ins[14:12];
        f3op = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        e = '0;
        e.wsel = 2'd3;
        e.cond = 3'b010;
        case (ins[6:0])
            7'h33: begin
                e.wen = 1; e.wsel = 0;
                e.aop = f3op[f3];
                if (ins[30] && f3 == 3'b000) e.aop = 4'd1;
                if (ins[30] && f3 == 3'b101) e.aop = 4'd7;
            end
            7'h13: begin
                e.wen = 1; e.wsel = 0; e.op2 = 1;
                e.aop = f3op[f3];
                if (ins[30] && f3 == 3'b101) e.aop = 4'd7;
            end
            7'h03: begin e.wen = 1; e.wsel = 1; e.op2 = 1; end
            7'h23: begin e.dwen = 1; e.op2 = 1; end
            7'h63: begin e.op1 = 1; e.op2 = 1; e.cond = f3; end
            7'h6F: begin e.wen = 1; e.wsel = 2; e.op1 = 1; e.op2 = 1; e.cond = 3'b011; end
            7'h67: begin e.wen = 1; e.wsel = 2; e.op2 = 1; e.cond = 3'b011; end
            7'h37: begin e.wen = 1; e.wsel = 0; e.op2 = 1; e.aop = 4'd10; end
            7'h17: begin e.wen = 1; e.wsel = 0; e.op1 = 1; e.op2 = 1; end
            default: ;
        endcase
        a = e.op1 ? p : r1;
        b = e.op2 ? im : r2;
        e.alu = ref_alu(e.aop, a, b);
        case (e.cond)
            3'b000: e.taken = (r1 == r2);
            3'b001: e.taken = (r1 != r2);
            3'b100: e.taken = ($signed(r1) < $signed(r2));
            3'b101: e.taken = !($signed(r1) < $signed(r2));
            3'b110: e.taken = (r1 < r2);
            3'b111: e.taken = !(r1 < r2);
            3'b011: e.taken = 1'b1;
            default: e.taken = 1'b0;
        endcase
        e.npc = p + 32'd4;
        if (ins[6:0] == 7'h63 && e.taken) e.npc = e.alu;
        if (ins[6:0] == 7'h6F) e.npc = e.alu;
        if (ins[6:0] == 7'h67) e.npc = e.alu & ~32'd1;
        return e;
    endfunction

    function automatic bit known_opcode(input logic [6:0] o);
        return o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    // Expected sticky flag
    logic m_ill;
    always @(posedge clk or posedge rst) begin
        if (rst) m_ill <= 1'b0;
        else if (!known_opcode(instruction[6:0])) m_ill <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (instr 0x%08h)", name, act, exp, instruction);
        end
    endtask

    // Compare process: every output against the model on each falling edge
    always @(negedge clk) begin
        if (checking) begin
            exp_t e;
            e = model(instruction, pc, imm, rs1_data, rs2_data);
            chk("rf_rsel1", {27'd0, rf_rsel1}, {27'd0, instruction[19:15]});
            chk("rf_rsel2", {27'd0, rf_rsel2}, {27'd0, instruction[24:20]});
            chk("rf_wsel",  {27'd0, rf_wsel},  {27'd0, instruction[11:7]});
            chk("rf_wen",   {31'd0, rf_wen},   {31'd0, e.wen});
            chk("dm_wen",   {31'd0, dm_wen},   {31'd0, e.dwen});
            chk("rf_wdata_sel", {30'd0, rf_wdata_sel}, {30'd0, e.wsel});
            chk("alu_op1_sel", {31'd0, alu_op1_sel}, {31'd0, e.op1});
            chk("alu_op2_sel", {31'd0, alu_op2_sel}, {31'd0, e.op2});
            chk("alu_operation", {28'd0, alu_operation}, {28'd0, e.aop});
            chk("branch_condition", {29'd0, branch_condition}, {29'd0, e.cond});
            chk("alu_out", alu_out, e.alu);
            chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.taken});
            chk("next_pc", next_pc, e.npc);
            chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
        end
    end

    // Drive one vector just after a rising edge, return just after the
    // following falling edge (when the compare process has sampled).
    task automatic apply(input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] im, input logic [31:0] r1,
                         input logic [31:0] r2);
        @(posedge clk);
        #1;
        instruction = ins; pc = p; imm = im; rs1_data = r1; rs2_data = r2;
        @(negedge clk);
        #1;
    endtask

    // Extra directed vectors, checked by the model only
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] p;
        logic [31:0] im;
        logic [31:0] r1;
        logic [31:0] r2;
    } vec_t;

    vec_t vecs [12] = '{
        '{32'h402081B3, 32'h100, 32'h0,        32'h5,        32'h7},         // SUB -> wraps
        '{32'h0020A1B3, 32'h104, 32'h0,        32'hFFFFFFFF, 32'h1},         // SLT
        '{32'h0020B1B3, 32'h108, 32'h0,        32'hFFFFFFFF, 32'h1},         // SLTU
        '{32'h4020D1B3, 32'h10C, 32'h0,        32'h80000000, 32'h21},        // SRA by 1
        '{32'h002091B3, 32'h110, 32'h0,        32'h1,        32'h3F},        // SLL by 31
        '{32'h0020C1B3, 32'h114, 32'h0,        32'hF0F0F0F0, 32'h0FF00FF0},  // XOR
        '{32'h0040D293, 32'h118, 32'h4,        32'h80000000, 32'h0},         // SRLI
        '{32'h0040A283, 32'h11C, 32'h8,        32'h1000,     32'h0},         // LW
        '{32'h00208063, 32'h120, 32'h40,       32'h1234,     32'h1234},      // BEQ taken
        '{32'h00209063, 32'h124, 32'h40,       32'h1234,     32'h1234},      // BNE not taken
        '{32'h0020F063, 32'hFFFFFFFC, 32'h10,  32'h5,        32'h5},         // BGEU taken
        '{32'h00001297, 32'hFFFFFFFC, 32'h1000, 32'h0,       32'h0}          // AUIPC wraps
    };

    initial begin
        // Reset state
        #12;
        checking = 1'b1;
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD x3,x1,x2 with signed overflow
        apply(32'h002081B3, 32'h80000000, 32'h0, 32'h7FFFFFFF, 32'h1);
        chk("add_alu", alu_out, 32'h80000000);
        chk("add_wen", {31'd0, rf_wen}, 32'd1);
        chk("add_wsel", {30'd0, rf_wdata_sel}, 32'd0);
        chk("add_rd", {27'd0, rf_wsel}, 32'd3);
        chk("add_npc", next_pc, 32'h80000004);

        // SRAI x5,x5,4
        apply(32'h4042D293, 32'h0, 32'h00000404, 32'h80000000, 32'h0);
        chk("srai_alu", alu_out, 32'hF8000000);
        chk("srai_op2", {31'd0, alu_op2_sel}, 32'd1);

        // ADDI with imm bit 10 set stays ADD
        apply(32'h40010093, 32'h0, 32'h00000400, 32'h5, 32'h0);
        chk("addi_op", {28'd0, alu_operation}, 32'd0);
        chk("addi_alu", alu_out, 32'h405);

        // BLT / BLTU with same operands
        apply(32'h0020C063, 32'h80000010, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h1);
        chk("blt_taken", {31'd0, branch_taken}, 32'd1);
        chk("blt_npc", next_pc, 32'h80000000);
        apply(32'h0020E063, 32'h80000010, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h1);
        chk("bltu_taken", {31'd0, branch_taken}, 32'd0);
        chk("bltu_npc", next_pc, 32'h80000014);

        // JALR clears bit 0; JAL
        apply(32'h002100E7, 32'h40, 32'h2, 32'h80000101, 32'h0);
        chk("jalr_npc", next_pc, 32'h80000102);
        chk("jalr_wsel", {30'd0, rf_wdata_sel}, 32'd2);
        chk("jalr_wen", {31'd0, rf_wen}, 32'd1);
        apply(32'h008000EF, 32'h80000000, 32'h8, 32'h0, 32'h0);
        chk("jal_npc", next_pc, 32'h80000008);

        // SW, LUI
        apply(32'h0020A223, 32'h0, 32'h4, 32'h100, 32'hDEAD);
        chk("sw_dwen", {31'd0, dm_wen}, 32'd1);
        chk("sw_wen", {31'd0, rf_wen}, 32'd0);
        chk("sw_alu", alu_out, 32'h104);
        apply(32'h123452B7, 32'h0, 32'h12345000, 32'hFFFF, 32'h0);
        chk("lui_alu", alu_out, 32'h12345000);

        // Model-only table
        foreach (vecs[i]) apply(vecs[i].ins, vecs[i].p, vecs[i].im, vecs[i].r1, vecs[i].r2);

        // Unknown opcode: flag rises at the next edge and sticks
        apply(32'h00000000, 32'h200, 32'h0, 32'h1, 32'h2);
        chk("ill_wen", {31'd0, rf_wen}, 32'd0);
        chk("ill_dwen", {31'd0, dm_wen}, 32'd0);
        chk("ill_before_edge", {31'd0, illegal}, 32'd0);
        apply(32'h002081B3, 32'h204, 32'h0, 32'h1, 32'h2);
        chk("ill_set", {31'd0, illegal}, 32'd1);
        apply(32'h00000013, 32'h208, 32'h0, 32'h1, 32'h2);
        chk("ill_sticky", {31'd0, illegal}, 32'd1);

        // Asynchronous reset mid-cycle clears it at once
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("ill_async_clear", {31'd0, illegal}, 32'd0);
        #1 rst = 1'b0;
        apply(32'h00000013, 32'h20C, 32'h0, 32'h1, 32'h2);
        chk("ill_after_rst", {31'd0, illegal}, 32'd0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
